// File: rtl/max_reduce_pkg.sv
// max_reduce_pkg: shared types/constants; CMP_LSB follows the MAX_REDUCE_APPROX_EN build option
package max_reduce_pkg;
    localparam int DEF_W = 5;
    localparam int DEF_LANES = 4;
    localparam int DEF_IDX_W = 8;
    localparam int DEF_APPROX_LSB = 1;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    typedef logic [clog2(DEF_LANES)-1:0] lane_idx_t;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
`ifdef MAX_REDUCE_APPROX_EN
    localparam int CMP_LSB = DEF_APPROX_LSB;
`else
    localparam int CMP_LSB = 0;
`endif
endpackage

// File: rtl/max_reduce_stream_node.sv
// max_cmp_node: larger of two {value,index} pairs compared on bits [W-1:LSB]; side a wins ties
module max_cmp_node import max_reduce_pkg::*; #(
    parameter int W   = DEF_W,
    parameter int IW  = 2,
    parameter int LSB = CMP_LSB
) (
    input  logic [W-1:0]  a_val,
    input  logic [IW-1:0] a_idx,
    input  logic [W-1:0]  b_val,
    input  logic [IW-1:0] b_idx,
    output logic [W-1:0]  val,
    output logic [IW-1:0] idx
);
    logic b_wins;
    assign b_wins = b_val[W-1:LSB] > a_val[W-1:LSB];
    assign val = b_wins ? b_val : a_val;
    assign idx = b_wins ? b_idx : a_idx;
endmodule

// File: rtl/max_reduce_stream.sv
// max_reduce_stream: pipelined frame max/argmax over LANES-wide beats; MAX_REDUCE_APPROX_EN truncates compares
module max_reduce_stream import max_reduce_pkg::*; #(
    parameter int W          = DEF_W,
    parameter int LANES      = DEF_LANES,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int APPROX_LSB = DEF_APPROX_LSB
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_max,
    output logic [IDX_W-1:0]   out_idx
);
    localparam int LW = clog2(LANES);
    localparam int BW = IDX_W - LW;
`ifdef MAX_REDUCE_APPROX_EN
    localparam bit APPROX_EN = 1'b1;
`else
    localparam bit APPROX_EN = 1'b0;
`endif
    localparam int CL = APPROX_EN ? APPROX_LSB : 0;
    localparam logic [W-1:0] MASK = ~((W'(1) << CL) - W'(1));
    state_t state, state_nx;
    logic s1_valid, s1_last, s1_first, mid;
    logic [W-1:0] t_val, s1_max, acc_max, c_max, n_max;
    logic [LW-1:0] t_idx;
    logic [IDX_W-1:0] s1_idx, acc_idx, c_idx, n_idx;
    logic [BW-1:0] beat;
    logic in_fire, s1_adv, load, out_fire;
    // heap-ordered tree: node n reads children 2n and 2n+1, leaves are lanes in order so ties favour lower lanes
    for (genvar n = 1; n < LANES; n++) begin : nd
        logic [W-1:0] av, bv, v;
        logic [LW-1:0] ai, bi, vi;
        if (2*n >= LANES) begin : lf
            assign av = in_data[(2*n-LANES)*W +: W];
            assign bv = in_data[(2*n+1-LANES)*W +: W];
            assign ai = LW'(2*n-LANES);
            assign bi = LW'(2*n+1-LANES);
        end else begin : br
            assign av = nd[2*n].v;
            assign bv = nd[2*n+1].v;
            assign ai = nd[2*n].vi;
            assign bi = nd[2*n+1].vi;
        end
        max_cmp_node #(.W(W), .IW(LW), .LSB(CL)) u_node (
            .a_val(av), .a_idx(ai), .b_val(bv), .b_idx(bi), .val(v), .idx(vi)
        );
    end
    assign t_val = nd[1].v;
    assign t_idx = nd[1].vi;
    max_cmp_node #(.W(W), .IW(IDX_W), .LSB(CL)) u_acc (
        .a_val(acc_max), .a_idx(acc_idx), .b_val(s1_max), .b_idx(s1_idx), .val(c_max), .idx(c_idx)
    );
    assign n_max = s1_first ? s1_max : c_max;
    assign n_idx = s1_first ? s1_idx : c_idx;
    assign out_valid = state == DONE;
    assign out_fire = out_valid && out_ready;
    assign s1_adv = s1_valid && !(s1_last && out_valid && !out_ready);
    assign in_ready = !s1_valid || s1_adv;
    assign in_fire = in_valid && in_ready;
    assign load = s1_adv && s1_last;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_fire) state_nx = ACC;
            ACC: if (load) state_nx = DONE;
            DONE: if (out_fire && !load) state_nx = (s1_valid || mid || in_fire) ? ACC : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_first <= 1'b0;
            s1_max   <= '0;
            s1_idx   <= '0;
            mid      <= 1'b0;
            beat     <= '0;
            acc_max  <= '0;
            acc_idx  <= '0;
            out_max  <= '0;
            out_idx  <= '0;
        end else begin
            state <= state_nx;
            if (in_ready) s1_valid <= in_valid;
            if (in_fire) begin
                s1_max   <= t_val;
                s1_idx   <= {beat, t_idx};
                s1_last  <= in_last;
                s1_first <= !mid;
                mid      <= !in_last;
                beat     <= in_last ? '0 : beat + 1'b1;
            end
            if (s1_adv) begin
                acc_max <= n_max;
                acc_idx <= n_idx;
            end
            if (load) begin
                out_max <= n_max & MASK;
                out_idx <= n_idx;
            end
        end
    end
endmodule
